pingpang_reader: RTL and testbench

Consumer-side engine for the two-bank ping-pong buffer. The write side fills one bank, flags it full, and moves to the other bank. This block reads each full bank in strict 0/1 alternation and streams the words out on a valid/ready interface with `last` marking the end of each frame. It then pulses a per-bank release back to the writer so the bank can be refilled. It sits between the bank RAMs' read port and the downstream consumer.

---
 rtl/pingpang_pkg.sv | 17 +
 rtl/pingpang_skid.sv | 69 ++++++
 rtl/pingpang_reader.sv | 106 ++++++++++
 tb/tb_pingpang_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpang_pkg.sv
// Shared types for the two-bank ping-pong buffer.
// Used by both the reader and the write side.
package pingpang_pkg;

  typedef enum logic [1:0] {
    PP_IDLE,
    PP_READ,
    PP_DRAIN
  } pp_state_t;

  typedef logic bank_t;

  function automatic logic [1:0] bank_onehot(bank_t b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pingpang_skid.sv
// Two-entry output FIFO with a registered head.
// Entry e0 is always the head, so dout comes straight from a flop.
module pingpang_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e1_q, e0_d, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         valid_q;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      cnt_q == 2'd0: begin
        if (push) begin
          e0_d  = din;
          cnt_d = 2'd1;
        end
      end
      cnt_q == 2'd1: begin
        if (push && pop) begin
          e0_d = din;
        end else if (push) begin
          e1_d  = din;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (push) e1_d = din;
          else cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign dout  = e0_q;
  assign valid = valid_q;
  assign count = cnt_q;

endmodule

// File: rtl/pingpang_reader.sv
// Reads full banks in strict 0/1 order and streams them out.
// Releases each bank to the writer after its last word is taken.
module pingpang_reader
  import pingpang_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        bank_full_i,
  output logic [1:0]        bank_release_o,
  output logic              mem_rd_en_o,
  output logic              mem_rd_bank_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last
);

  localparam int SW = DATA_W + 1;

  pp_state_t         state_q, state_d;
  bank_t             cur_bank_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              in_flight_q;
  logic              in_flight_last_q;
  logic [1:0]        release_q;

  logic [SW-1:0]     head;
  logic              fifo_valid;
  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              last_addr;
  logic [2:0]        occ;
  logic              rd_en;
  logic              frame_done;

  assign pop       = fifo_valid && dout_ready;
  assign last_addr = (rd_addr_q == ADDR_W'(DEPTH - 1));
  // Words buffered or in flight once this cycle's pop leaves
  assign occ = {1'b0, fifo_cnt} + {2'b00, in_flight_q} - {2'b00, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PP_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PP_IDLE:  if (bank_full_i[cur_bank_q]) state_d = PP_READ;
      PP_READ:  if (rd_en && last_addr) state_d = PP_DRAIN;
      PP_DRAIN: if (frame_done) state_d = PP_IDLE;
      default:  state_d = PP_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = (state_q == PP_READ) && (occ < 3'd2);
    frame_done = (state_q == PP_DRAIN) && pop && head[DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_bank_q       <= 1'b0;
      rd_addr_q        <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      release_q        <= 2'b00;
    end else begin
      in_flight_q      <= rd_en;
      in_flight_last_q <= rd_en && last_addr;
      release_q        <= frame_done ? bank_onehot(cur_bank_q) : 2'b00;
      if (frame_done) begin
        cur_bank_q <= ~cur_bank_q;
        rd_addr_q  <= '0;
      end else if (rd_en && !last_addr) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  pingpang_skid #(.W(SW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_flight_q),
    .din   ({in_flight_last_q, mem_rd_data_i}),
    .pop   (pop),
    .dout  (head),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  assign mem_rd_en_o    = rd_en;
  assign mem_rd_bank_o  = cur_bank_q;
  assign mem_rd_addr_o  = rd_addr_q;
  assign bank_release_o = release_q;
  assign dout           = head[DATA_W-1:0];
  assign dout_last      = head[DATA_W];
  assign dout_valid     = fifo_valid;

endmodule

// File: tb/tb_pingpang_reader.sv
// Scoreboard bench for pingpang_reader with DEPTH=4.
// Frames are queued per bank at fill time and drained in 0/1 order.
module tb_pingpang_reader;

  localparam int DW = 16;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    full = 2'b00;
  logic [1:0]    rel;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] dout;
  logic          dv;
  logic          dr = 1'b0;
  logic          dl;

  always #5 clk = ~clk;

  pingpang_reader #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bank_full_i    (full),
    .bank_release_o (rel),
    .mem_rd_en_o    (rd_en),
    .mem_rd_bank_o  (rd_bank),
    .mem_rd_addr_o  (rd_addr),
    .mem_rd_data_i  (rd_data),
    .dout           (dout),
    .dout_valid     (dv),
    .dout_ready     (dr),
    .dout_last      (dl)
  );

  logic [DW-1:0] mem [2][D];

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({rel, rd_en, rd_bank, rd_addr, dout, dv, dl});
  endfunction

  // Reference model: expected words per bank, consumed 0,1,0,1...
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            exp_bank = 1'b0;
  int            widx = 0;
  logic [1:0]    pend_rel = 2'b00;
  int            rel_due = 0;
  int            cyc = 0;
  int            issued = 0;
  int            popped = 0;
  int            words_seen = 0;
  int            rel_seen = 0;
  int            fstart = 0;
  int            span = 0;
  bit            rnd_on = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    bit            emp;
    if (rst_n) begin
      cyc++;
      chk("outstanding_le_2", 64'(issued - popped <= 2), 64'd1);
      if (rd_en) issued++;
      if (dv && dr) begin
        popped++;
        words_seen++;
        emp = exp_bank ? (q1.size() == 0) : (q0.size() == 0);
        if (emp) begin
          chk("unexpected_word", 64'(dv && dr), 64'd0);
        end else begin
          w = exp_bank ? q1.pop_front() : q0.pop_front();
          chk("word", 64'({dl, dout}), 64'({widx == D - 1, w}));
          if (widx == 0) fstart = cyc;
          if (widx == D - 1) begin
            span     = cyc - fstart;
            pend_rel = exp_bank ? 2'b10 : 2'b01;
            rel_due  = cyc + 1;
            exp_bank = ~exp_bank;
            widx     = 0;
          end else begin
            widx++;
          end
        end
      end
      if (rel != 2'b00) begin
        chk("release_bank", 64'(rel), 64'(pend_rel));
        if (pend_rel != 2'b00) chk("release_time", 64'(cyc), 64'(rel_due));
        full     = full & ~rel;
        pend_rel = 2'b00;
        rel_seen++;
      end else if (pend_rel != 2'b00 && cyc >= rel_due) begin
        chk("release_missing", 64'(rel), 64'(pend_rel));
        pend_rel = 2'b00;
      end
    end
  end

  always @(posedge clk)
    if (rnd_on) begin
      #1;
      dr = ($urandom_range(0, 3) != 0);
    end

  task automatic clear_model();
    q0.delete();
    q1.delete();
    exp_bank = 1'b0;
    widx     = 0;
    pend_rel = 2'b00;
    issued   = 0;
    popped   = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    full  = 2'b00;
    dr    = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fill(input int b, input bit rnd, input int base,
                      input int step);
    logic [DW-1:0] w;
    for (int i = 0; i < D; i++) begin
      w = rnd ? DW'($urandom) : DW'(base + i * step);
      mem[b][i] = w;
      if (b == 0) q0.push_back(w);
      else q1.push_back(w);
    end
  endtask

  task automatic wait_rel(input int target, input int budget);
    int n = 0;
    while (rel_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("wait_release", 64'(rel_seen), 64'(target));
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (words_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_words", 64'(words_seen), 64'(target));
  endtask

  initial begin
    int r0;
    int w0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < D; i++) mem[b][i] = '0;

    // Reset state, then idle with no stimulus
    #2 chk("reset_outs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 chk("idle_outs", outs(), 64'd0);
    end

    // Single frame with exact latency
    do_reset();
    fill(0, 1'b0, 0, 10);
    dr = 1'b1;
    r0 = rel_seen;
    @(posedge clk);
    #1 full = 2'b01;
    @(posedge clk);
    #1 chk("rd_en_T1", 64'({rd_en, rd_bank, rd_addr}), 64'({1'b1, 1'b0, 2'd0}));
    chk("no_valid_T1", 64'(dv), 64'd0);
    @(posedge clk);
    #1 chk("no_valid_T2", 64'(dv), 64'd0);
    @(posedge clk);
    #1 chk("first_valid", 64'({dv, dout}), 64'({1'b1, 16'd0}));
    wait_rel(r0 + 1, 40);
    chk("frame_span", 64'(span), 64'(D - 1));
    chk("q0_empty", 64'(q0.size()), 64'd0);

    // Both banks full back to back
    do_reset();
    fill(0, 1'b0, 0, 10);
    fill(1, 1'b0, 1, 1);
    dr = 1'b1;
    r0 = rel_seen;
    full = 2'b11;
    wait_rel(r0 + 2, 80);
    chk("both_empty", 64'(q0.size() + q1.size()), 64'd0);

    // Backpressure for 5 cycles after the first word
    do_reset();
    fill(0, 1'b1, 0, 0);
    dr = 1'b1;
    r0 = rel_seen;
    w0 = words_seen;
    full = 2'b01;
    wait_words(w0 + 1, 40);
    @(posedge clk);
    #1 dr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("stall_rd_en", 64'({rd_en, dv}), 64'({1'b0, 1'b1}));
    repeat (2) @(posedge clk);
    #1 dr = 1'b1;
    wait_rel(r0 + 1, 40);
    chk("stall_q0_empty", 64'(q0.size()), 64'd0);

    // Only bank1 flagged: nothing happens until bank0 is flagged
    do_reset();
    fill(1, 1'b0, 50, 3);
    dr = 1'b1;
    r0 = rel_seen;
    w0 = words_seen;
    full = 2'b10;
    repeat (10) @(posedge clk);
    #1 chk("b1_only_no_read", 64'(issued), 64'd0);
    chk("b1_only_no_word", 64'(words_seen), 64'(w0));
    fill(0, 1'b0, 70, 2);
    full[0] = 1'b1;
    wait_rel(r0 + 2, 80);
    chk("order_empty", 64'(q0.size() + q1.size()), 64'd0);

    // Reset after the second word aborts the frame
    do_reset();
    fill(0, 1'b0, 100, 1);
    dr = 1'b1;
    w0 = words_seen;
    full = 2'b01;
    wait_words(w0 + 2, 40);
    @(posedge clk);
    #1 rst_n = 1'b0;
    full = 2'b00;
    clear_model();
    #1 chk("abort_outs", outs(), 64'd0);
    r0 = rel_seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("abort_no_release", 64'(rel_seen), 64'(r0));
    fill(0, 1'b0, 200, 1);
    full = 2'b01;
    wait_rel(r0 + 1, 40);
    chk("restart_empty", 64'(q0.size()), 64'd0);

    // Random data and random backpressure over many frames
    do_reset();
    r0 = rel_seen;
    rnd_on = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int b;
      int n;
      b = f % 2;
      n = 0;
      while (full[b] && n < 200) begin
        @(posedge clk);
        n++;
      end
      @(posedge clk);
      #2 fill(b, 1'b1, 0, 0);
      full[b] = 1'b1;
    end
    wait_rel(r0 + 12, 600);
    rnd_on = 1'b0;
    chk("rand_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
